// File: rtl/fine_track_seq.sv
// Bring-up sequencer for the fine frequency tracking loop: aux calibration,
// coarse gear, fine gear and lock, judged on the fed-back oscillator code every EVAL_PERIOD cycles.
module fine_track_seq #(
  parameter int         AUX_CYCLES  = 64,
  parameter int         EVAL_PERIOD = 256,
  parameter int         LOCK_TOL    = 2,
  parameter int         UNLOCK_TOL  = 8,
  parameter int         GEAR_STABLE = 4,
  parameter int         LOCK_STABLE = 8,
  parameter logic [4:0] COARSE_WIN  = 5'd1
) (
  input  logic        ref_clk,
  input  logic        rst,
  input  logic        seq_en,
  input  logic [12:0] osc_code,
  input  logic [4:0]  win_sel_cfg,
  input  logic [3:0]  step_hi_cfg,
  input  logic [3:0]  step_lo_cfg,
  output logic        aux_osc_en,
  output logic        fftl_en,
  output logic [4:0]  fine_control_avg_window_select,
  output logic [3:0]  fine_con_step_size,
  output logic        lock,
  output logic        relock_pulse,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_AUX_CAL = 3'd1,
    S_COARSE  = 3'd2,
    S_FINE    = 3'd3,
    S_LOCKED  = 3'd4
  } state_t;

  localparam int               CNT_MAX        = (AUX_CYCLES > EVAL_PERIOD) ? AUX_CYCLES : EVAL_PERIOD;
  localparam int               CNT_W          = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] AUX_LAST       = CNT_W'(AUX_CYCLES - 1);
  localparam logic [CNT_W-1:0] EVAL_LAST      = CNT_W'(EVAL_PERIOD - 1);
  localparam logic [12:0]      LOCK_TOL_C     = 13'(LOCK_TOL);
  localparam logic [12:0]      UNLOCK_TOL_C   = 13'(UNLOCK_TOL);
  localparam logic [3:0]       GEAR_STABLE_C  = 4'(GEAR_STABLE);
  localparam logic [3:0]       LOCK_STABLE_C  = 4'(LOCK_STABLE);
  localparam logic [12:0]      CODE_MAX       = '1;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [12:0]      r_prev;
  logic             r_prev_valid;
  logic [3:0]       r_stable;
  logic             r_aux_osc_en;
  logic             r_fftl_en;
  logic [4:0]       r_win;
  logic [3:0]       r_step;
  logic             r_lock;
  logic             r_relock;

  state_t      w_next;
  logic        w_in_track;
  logic        w_tick;
  logic        w_cmp;
  logic        w_rail;
  logic        w_settled;
  logic        w_jump;
  logic [12:0] w_delta;
  logic [3:0]  w_stable_inc;
  logic [3:0]  w_stable_next;

  always_comb begin
    // NOTE: every signal gets a value before the case so no path leaves one unassigned (no latch).
    w_in_track    = (r_state == S_COARSE) || (r_state == S_FINE) || (r_state == S_LOCKED);
    w_tick        = w_in_track && (r_cnt == EVAL_LAST);
    w_cmp         = w_tick && r_prev_valid;
    w_delta       = (osc_code >= r_prev) ? (osc_code - r_prev) : (r_prev - osc_code);
    w_settled     = (w_delta <= LOCK_TOL_C);
    w_jump        = (w_delta > UNLOCK_TOL_C);
    w_rail        = (osc_code == 13'd0) || (osc_code == CODE_MAX);
    w_stable_inc  = (r_stable == 4'hF) ? r_stable : r_stable + 4'd1;
    w_stable_next = w_settled ? w_stable_inc : 4'd0;
    w_next        = r_state;

    case (r_state)
      S_IDLE:    w_next = S_AUX_CAL;
      S_AUX_CAL: if (r_cnt == AUX_LAST) w_next = S_COARSE;
      S_COARSE:  if (w_cmp && (w_stable_next >= GEAR_STABLE_C)) w_next = S_FINE;
      S_FINE: begin
        if (w_tick && w_rail)                                   w_next = S_COARSE;
        else if (w_cmp && (w_stable_next >= LOCK_STABLE_C))     w_next = S_LOCKED;
      end
      S_LOCKED:  if (w_tick && (w_rail || (r_prev_valid && w_jump))) w_next = S_COARSE;
      default:   w_next = S_IDLE;
    endcase

    // Disable beats every other event, including a same-cycle unlock.
    if (!seq_en) w_next = S_IDLE;
  end

  always_ff @(posedge ref_clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_prev       <= '0;
      r_prev_valid <= 1'b0;
      r_stable     <= '0;
      r_aux_osc_en <= 1'b0;
      r_fftl_en    <= 1'b0;
      r_win        <= '0;
      r_step       <= '0;
      r_lock       <= 1'b0;
      r_relock     <= 1'b0;
    end else begin
      r_state <= w_next;

      if ((w_next != r_state) || w_tick || (w_next == S_IDLE)) r_cnt <= '0;
      else                                                   r_cnt <= r_cnt + 1'b1;

      if (w_tick) begin
        r_prev       <= osc_code;
        r_prev_valid <= 1'b1;
        if (r_prev_valid) r_stable <= w_stable_next;
      end

      // NOTE: these entry clears are non-blocking and come later, so they override the tick update above.
      if (w_next != r_state) begin
        if ((w_next == S_COARSE) || (w_next == S_IDLE)) begin
          r_prev_valid <= 1'b0;
          r_stable     <= '0;
        end else if (w_next == S_FINE) begin
          r_stable <= '0;
        end
      end

      r_relock     <= (w_next == S_COARSE) && ((r_state == S_FINE) || (r_state == S_LOCKED));
      r_lock       <= (w_next == S_LOCKED);
      r_aux_osc_en <= (w_next != S_IDLE);
      r_fftl_en    <= (w_next == S_COARSE) || (w_next == S_FINE) || (w_next == S_LOCKED);

      case (w_next)
        S_COARSE: begin
          r_step <= step_hi_cfg;
          r_win  <= COARSE_WIN;
        end
        S_FINE, S_LOCKED: begin
          r_step <= step_lo_cfg;
          r_win  <= win_sel_cfg;
        end
        default: begin
          r_step <= '0;
          r_win  <= '0;
        end
      endcase
    end
  end

  assign state                          = r_state;
  assign aux_osc_en                     = r_aux_osc_en;
  assign fftl_en                        = r_fftl_en;
  assign fine_control_avg_window_select = r_win;
  assign fine_con_step_size             = r_step;
  assign lock                           = r_lock;
  assign relock_pulse                   = r_relock;

endmodule

// File: tb/tb_fine_track_seq.sv
// Self-checking bench for fine_track_seq: directed bring-up/unlock/rail/disable/reset
// scenarios plus randomized code and config traffic against a cycle-level reference model.
module tb_fine_track_seq;

  localparam int AUX_CYCLES  = 64;
  localparam int EVAL_PERIOD = 256;
  localparam int LOCK_TOL    = 2;
  localparam int UNLOCK_TOL  = 8;
  localparam int GEAR_STABLE = 4;
  localparam int LOCK_STABLE = 8;

  localparam int IDLE   = 0;
  localparam int AUX    = 1;
  localparam int COARSE = 2;
  localparam int FINE   = 3;
  localparam int LOCKED = 4;

  logic        ref_clk = 1'b0;
  logic        rst;
  logic        seq_en;
  logic [12:0] osc_code;
  logic [4:0]  win_sel_cfg;
  logic [3:0]  step_hi_cfg;
  logic [3:0]  step_lo_cfg;
  logic        aux_osc_en;
  logic        fftl_en;
  logic [4:0]  fine_control_avg_window_select;
  logic [3:0]  fine_con_step_size;
  logic        lock;
  logic        relock_pulse;
  logic [2:0]  state;

  int checks   = 0;
  int failures = 0;

  fine_track_seq dut (
    .ref_clk                        (ref_clk),
    .rst                            (rst),
    .seq_en                         (seq_en),
    .osc_code                       (osc_code),
    .win_sel_cfg                    (win_sel_cfg),
    .step_hi_cfg                    (step_hi_cfg),
    .step_lo_cfg                    (step_lo_cfg),
    .aux_osc_en                     (aux_osc_en),
    .fftl_en                        (fftl_en),
    .fine_control_avg_window_select (fine_control_avg_window_select),
    .fine_con_step_size             (fine_con_step_size),
    .lock                           (lock),
    .relock_pulse                   (relock_pulse),
    .state                          (state)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: mode, cycles since mode entry, last captured code, run of settled evaluations.
  int          m_state;
  int          m_cnt;
  int          m_prev;
  bit          m_pv;
  int          m_stable;
  logic [15:0] m_out;

  function automatic logic [15:0] pack_dut();
    return {state, aux_osc_en, fftl_en, fine_control_avg_window_select, fine_con_step_size, lock, relock_pulse};
  endfunction

  function automatic logic [15:0] drive_of(int st, logic [4:0] win, logic [3:0] hi, logic [3:0] lo, bit relock);
    logic       aux, fftl, lk;
    logic [4:0] w;
    logic [3:0] s;
    aux  = (st != IDLE);
    fftl = (st >= COARSE);
    lk   = (st == LOCKED);
    w    = (st == COARSE) ? 5'd1 : ((st >= FINE) ? win : 5'd0);
    s    = (st == COARSE) ? hi   : ((st >= FINE) ? lo  : 4'd0);
    return {3'(st), aux, fftl, w, s, lk, relock};
  endfunction

  function automatic void model_reset();
    m_state  = IDLE;
    m_cnt    = 0;
    m_prev   = 0;
    m_pv     = 0;
    m_stable = 0;
    m_out    = '0;
  endfunction

  function automatic void model_edge(bit en, int code, logic [4:0] win, logic [3:0] hi, logic [3:0] lo);
    int nxt, d;
    bit tick, cmp, rail, relock;
    nxt  = m_state;
    tick = (m_state >= COARSE) && (m_cnt == EVAL_PERIOD - 1);
    cmp  = tick && m_pv;
    d    = (code > m_prev) ? code - m_prev : m_prev - code;
    rail = (code == 0) || (code == 8191);
    if (!en) nxt = IDLE;
    else begin
      case (m_state)
        IDLE:   nxt = AUX;
        AUX:    if (m_cnt == AUX_CYCLES - 1) nxt = COARSE;
        COARSE: if (cmp && d <= LOCK_TOL && m_stable + 1 >= GEAR_STABLE) nxt = FINE;
        FINE: begin
          if (tick && rail) nxt = COARSE;
          else if (cmp && d <= LOCK_TOL && m_stable + 1 >= LOCK_STABLE) nxt = LOCKED;
        end
        LOCKED: if (tick && (rail || (m_pv && d > UNLOCK_TOL))) nxt = COARSE;
        default: nxt = IDLE;
      endcase
    end
    if (tick) begin
      if (m_pv) m_stable = (d <= LOCK_TOL) ? m_stable + 1 : 0;
      m_prev = code;
      m_pv   = 1;
    end
    relock = (nxt == COARSE) && (m_state == FINE || m_state == LOCKED);
    if (nxt != m_state) begin
      m_cnt = 0;
      if (nxt == COARSE || nxt == IDLE) begin m_pv = 0; m_stable = 0; end
      else if (nxt == FINE) m_stable = 0;
    end else if (tick) m_cnt = 0;
    else m_cnt++;
    m_state = nxt;
    m_out   = drive_of(nxt, win, hi, lo, relock);
  endfunction

  task automatic cycle();
    @(posedge ref_clk);
    model_edge(seq_en, int'(osc_code), win_sel_cfg, step_hi_cfg, step_lo_cfg);
    #1;
    check("outs", 32'(pack_dut()), 32'(m_out));
  endtask

  task automatic run_to_pre_tick();
    int n = 0;
    while (!(m_state >= COARSE && m_cnt == EVAL_PERIOD - 1) && n < 2 * EVAL_PERIOD) begin
      cycle();
      n++;
    end
    if (n >= 2 * EVAL_PERIOD) check("pre_tick_timeout", 32'(n), 32'(0));
  endtask

  task automatic run_to_state(input string tag, input int target, input int budget);
    int n = 0;
    while (int'(state) != target && n < budget) begin
      cycle();
      n++;
    end
    check(tag, 32'(state), 32'(target));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    seq_en      = 1'b0;
    osc_code    = 13'd4096;
    win_sel_cfg = 5'd7;
    step_hi_cfg = 4'd9;
    step_lo_cfg = 4'd3;
    model_reset();
    repeat (3) @(posedge ref_clk);
    #1;
    check("reset_outs", 32'(pack_dut()), 32'(0));
    rst = 1'b0;
    cycle();

    // Bring-up with a constant code; edge n counts from the first edge that sees seq_en high.
    seq_en = 1'b1;
    for (int n = 1; n <= 3393; n++) begin
      cycle();
      if (n == 1)    check("bringup_aux", 32'(state), 32'(AUX));
      if (n == 64)   check("aux_last_cycle", 32'(state), 32'(AUX));
      if (n == 65) begin
        check("bringup_coarse", 32'(state), 32'(COARSE));
        check("coarse_step", 32'(fine_con_step_size), 32'(4'd9));
        check("coarse_win", 32'(fine_control_avg_window_select), 32'(5'd1));
      end
      if (n == 1344) check("coarse_hold", 32'(state), 32'(COARSE));
      if (n == 1345) begin
        check("bringup_fine", 32'(state), 32'(FINE));
        check("fine_step", 32'(fine_con_step_size), 32'(4'd3));
        check("fine_win", 32'(fine_control_avg_window_select), 32'(5'd7));
      end
      if (n == 3392) check("fine_hold", 32'(state), 32'(FINE));
      if (n == 3393) begin
        check("bringup_locked", 32'(state), 32'(LOCKED));
        check("bringup_lock", 32'(lock), 32'(1));
      end
    end

    // Jump of exactly UNLOCK_TOL holds lock; one more drops it.
    run_to_pre_tick();
    osc_code = 13'd4104;
    cycle();
    check("jump8_stays_locked", 32'(state), 32'(LOCKED));
    run_to_pre_tick();
    osc_code = 13'd4113;
    cycle();
    check("jump9_state", 32'(state), 32'(COARSE));
    check("jump9_lock", 32'(lock), 32'(0));
    check("jump9_relock", 32'(relock_pulse), 32'(1));
    check("jump9_step", 32'(fine_con_step_size), 32'(4'd9));
    cycle();
    check("relock_one_cycle", 32'(relock_pulse), 32'(0));

    // Step of 3 on the 5th FINE tick restarts the settle count.
    run_to_state("reach_fine_break", FINE, 6 * EVAL_PERIOD + 10);
    for (int t = 1; t <= 13; t++) begin
      run_to_pre_tick();
      if (t == 5) osc_code = osc_code + 13'd3;
      cycle();
      if (t == 5)  check("break_stays_fine", 32'(state), 32'(FINE));
      if (t == 12) check("no_early_lock", 32'(state), 32'(FINE));
      if (t == 13) check("lock_after_break", 32'(state), 32'(LOCKED));
    end

    // Disable on the same edge as an unlock tick.
    run_to_pre_tick();
    osc_code = osc_code + 13'd20;
    seq_en   = 1'b0;
    cycle();
    check("drop_idle_outs", 32'(pack_dut()), 32'(0));
    seq_en   = 1'b1;
    osc_code = 13'd4096;
    cycle();
    check("restart_aux", 32'(state), 32'(AUX));

    // Rail in FINE.
    run_to_state("reach_fine_rail", FINE, AUX_CYCLES + 6 * EVAL_PERIOD + 10);
    run_to_pre_tick();
    osc_code = 13'd8191;
    cycle();
    check("rail_fine_state", 32'(state), 32'(COARSE));
    check("rail_fine_relock", 32'(relock_pulse), 32'(1));
    osc_code = 13'd4096;

    // Asynchronous reset between edges while in COARSE.
    repeat (10) cycle();
    #3;
    rst = 1'b1;
    #1;
    check("async_reset_outs", 32'(pack_dut()), 32'(0));
    model_reset();
    #1;
    rst = 1'b0;
    cycle();
    check("post_reset_aux", 32'(state), 32'(AUX));

    // Low rail while LOCKED.
    run_to_state("reach_locked_rail", LOCKED, AUX_CYCLES + 14 * EVAL_PERIOD);
    run_to_pre_tick();
    osc_code = 13'd0;
    cycle();
    check("rail_locked_state", 32'(state), 32'(COARSE));
    check("rail_locked_relock", 32'(relock_pulse), 32'(1));
    osc_code = 13'd4096;

    // Randomized code walk, config changes and enable drops.
    for (int i = 0; i < 40000; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        if (osc_code == 13'd0 || osc_code == 13'h1FFF) osc_code = 13'd4096;
        else osc_code = 13'(int'(osc_code) + int'($urandom_range(0, 24)) - 12);
      end
      if ($urandom_range(0, 14999) == 0) osc_code = ($urandom_range(0, 1) == 1) ? 13'h1FFF : 13'h0000;
      if ($urandom_range(0, 99) == 0) begin
        win_sel_cfg = 5'($urandom_range(0, 31));
        step_hi_cfg = 4'($urandom_range(0, 15));
        step_lo_cfg = 4'($urandom_range(0, 15));
      end
      if (seq_en && $urandom_range(0, 7999) == 0) seq_en = 1'b0;
      else if (!seq_en && $urandom_range(0, 15) == 0) seq_en = 1'b1;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fine_track_seq.md
# fine_track_seq

Sequencer for the fine frequency tracking loop. It brings the loop up in order: aux oscillator calibration, then coarse-gear tracking, then fine-gear tracking, then lock. It gear-shifts the loop's step size and averaging window, watches the fed-back oscillator code for settling, and declares or drops lock. It sits beside `fine_freq_track` in the digital top, drives its `aux_osc_en`, `fftl_en`, `fine_con_step_size` and `fine_control_avg_window_select` inputs, and reads back `osc_fine_con_final`.

## Interface
- AUX_CYCLES, 64: ref_clk cycles spent in AUX_CAL.
- EVAL_PERIOD, 256: ref_clk cycles between code evaluations (ticks).
- LOCK_TOL, 2: max |Δcode| per tick that counts as stable.
- UNLOCK_TOL, 8: |Δcode| per tick above which LOCKED is dropped.
- GEAR_STABLE, 4: consecutive stable ticks needed for COARSE→FINE.
- LOCK_STABLE, 8: consecutive stable ticks needed for FINE→LOCKED.
- COARSE_WIN, 5'd1: averaging window used in COARSE.

Ports:
- ref_clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- seq_en  in  1  level enable; 0 forces IDLE.
- osc_code  in  13  fed back from `osc_fine_con_final`.
- win_sel_cfg  in  5  averaging window used in FINE and LOCKED.
- step_hi_cfg  in  4  step size used in COARSE.
- step_lo_cfg  in  4  step size used in FINE and LOCKED.
- aux_osc_en  out  1  aux oscillator enable.
- fftl_en  out  1  tracking loop enable.
- fine_control_avg_window_select  out  5  window to the loop.
- fine_con_step_size  out  4  step to the loop.
- lock  out  1  loop locked.
- relock_pulse  out  1  one-cycle pulse on any drop back to COARSE.
- state  out  3  encoding: IDLE=0, AUX_CAL=1, COARSE=2, FINE=3, LOCKED=4.

## Operation
- **IDLE**
  - All outputs are 0.
  - seq_en=1 → AUX_CAL.
- **AUX_CAL**
  - aux_osc_en=1, fftl_en=0, step=0, window=0.
  - Leaves after exactly AUX_CYCLES cycles → COARSE.
- **COARSE**
  - aux_osc_en=1, fftl_en=1, step=step_hi_cfg, window=COARSE_WIN.
  - stable_cnt reaches GEAR_STABLE → FINE.
- **FINE**
  - aux_osc_en=1, fftl_en=1, step=step_lo_cfg, window=win_sel_cfg.
  - stable_cnt reaches LOCK_STABLE → LOCKED.
- **LOCKED**
  - Same drive as FINE, plus lock=1.
  - On a tick with |Δcode|>UNLOCK_TOL → COARSE.
  - On a tick with osc_code at a rail (0 or 8191) → COARSE.
- **Rail check in FINE:** a tick with osc_code at a rail (0 or 8191) also sends FINE → COARSE.
- **Evaluation**
  - The tick counter restarts on every state entry; a tick fires when the counter = EVAL_PERIOD-1.
  - On a tick with prev_valid=0: capture prev=osc_code, set prev_valid=1, no comparison.
  - Otherwise: Δ=|osc_code−prev| on 13-bit unsigned values, no wrap. Δ≤LOCK_TOL increments stable_cnt (saturating), else stable_cnt is cleared. Then prev=osc_code.
  - Entering COARSE clears prev_valid and stable_cnt.
  - COARSE→FINE clears stable_cnt and keeps prev.
- **Config inputs** cfg inputs are sampled every cycle, so changes are reflected on the next edge.

## Timing
- Reset value of every output is 0; state=IDLE. Internal counters are cleared too.
- Outputs are registered and change on the same edge as state.
- seq_en low dominates every other event; IDLE is entered on the next edge.
- Reset mid-operation: asynchronous; all outputs go to 0 immediately.
- seq_en re-rise after a drop restarts from AUX_CAL.
- Nominal timeline after seq_en is sampled high at edge 0:
  - AUX_CAL at edge 1.
  - COARSE at edge 1+AUX_CYCLES.
  - FINE: (1+GEAR_STABLE)·EVAL_PERIOD cycles after COARSE entry, with a settled code.
  - LOCKED: LOCK_STABLE·EVAL_PERIOD cycles after FINE entry.
- relock_pulse is high for exactly the cycle in which state first reads COARSE after LOCKED or FINE.
- It is not asserted on AUX_CAL→COARSE.
- Tick and transition on the same cycle: the transition is taken; the tick's prev update still applies.

## Test plan
- **Bring-up, constant osc_code=4096, defaults:**
  - state=1 at edge 1, state=2 at edge 65.
  - state=3 at edge 65+1280; step=step_lo_cfg and window=win_sel_cfg on that edge.
  - state=4 and lock=1 at edge 65+1280+2048.
- **Stability break in FINE:** osc_code steps by 3 at the 5th tick → stable_cnt clears; LOCKED occurs 8 ticks after the step, not before.
- **Unlock from LOCKED:**
  - Code jump of 9 → next edge: state=2, lock=0, relock_pulse high for 1 cycle, step=step_hi_cfg.
  - Code jump of 8 → stays LOCKED.
- **Rail:** osc_code=8191 on a tick in FINE → COARSE with relock_pulse.
- **seq_en drop:** seq_en=0 during LOCKED, on the same cycle as an unlock tick → IDLE next edge, all outputs 0, no relock_pulse.
- **Async reset:** rst asserted mid-COARSE between clock edges → outputs 0 immediately; after release with seq_en=1 → AUX_CAL one edge later.
